// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t            - arbiter FSM state encoding
//   MASK_WORD              - full-word byte mask used for instruction fetches
//   TIMEOUT_CYCLES_DEFAULT - default bus-wait limit when the timeout is built in
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2
  } arb_state_t;

  localparam logic [3:0]  MASK_WORD              = 4'b1111;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: bus-wait watchdog for the memory port arbiter.
// Only compiled when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (count -> 0)
//   load      - reload with LOAD_VAL (grant edge)
//   run       - count down while a grant is outstanding
//   expired   - terminal count reached while running; the next edge is the
//               LOAD_VAL+1'th edge spent waiting
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_ctr #(
  parameter logic [7:0] LOAD_VAL = 8'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (run && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign expired = run && (cnt_q == 8'd0);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (if_*) and a data requester (dm_*).
// Optional feature macro: MEM_ARB_TIMEOUT_EN (bus-wait timeout with err pulse).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   if_req/if_addr      - fetch request; if_ack/if_rdata response
//   dm_req/dm_we/dm_mask/dm_addr/dm_wdata - data request; dm_ack/dm_rdata response
//   bus_*               - registered shared-port request fields
//   bus_valid/bus_rdata - memory completion and read data
//   err                 - one-cycle pulse on timeout abort (0 without the macro)
//
// state     | meaning
// ST_IDLE   | no transaction; arbitrate pending requests
// ST_GNT_IF | fetch owns the port, waiting for bus_valid
// ST_GNT_DM | data port owns the port, waiting for bus_valid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_mask,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        bus_request,
  output logic        bus_we_re,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_valid,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be 2..255");
  end

  arb_state_t state_q, state_d;
  logic       last_dm_q;
  logic       in_gnt;
  logic       grant_edge;
  logic       timeout_hit;

  assign in_gnt     = (state_q != ST_IDLE);
  assign grant_edge = (state_q == ST_IDLE) && (state_d != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  logic tmo_expired;
  logic err_q;

  arb_timeout_ctr #(
    .LOAD_VAL (8'(TIMEOUT_CYCLES - 1))
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_edge),
    .run     (in_gnt),
    .expired (tmo_expired)
  );

  // A completion in the expiring cycle wins over the abort.
  assign timeout_hit = tmo_expired && !bus_valid;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= timeout_hit;
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_dm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Tie-break history only tracks grants that actually completed.
      if (in_gnt && bus_valid) last_dm_q <= (state_q == ST_GNT_DM);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dm_req && !(if_req && last_dm_q)) state_d = ST_GNT_DM;
        else if (if_req)                      state_d = ST_GNT_IF;
      end
      ST_GNT_IF, ST_GNT_DM: begin
        if (bus_valid || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once at grant and left untouched until the
  // next grant, so the port sees stable values for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_request <= 1'b0;
      bus_we_re   <= 1'b0;
      bus_mask    <= 4'b0000;
      bus_addr    <= 32'd0;
      bus_wdata   <= 32'd0;
    end else if (grant_edge && (state_d == ST_GNT_DM)) begin
      bus_request <= 1'b1;
      bus_we_re   <= dm_we;
      bus_mask    <= dm_mask;
      bus_addr    <= dm_addr;
      bus_wdata   <= dm_wdata;
    end else if (grant_edge) begin
      bus_request <= 1'b1;
      bus_we_re   <= 1'b0;
      bus_mask    <= MASK_WORD;
      bus_addr    <= if_addr;
      bus_wdata   <= 32'd0;
    end else if (in_gnt && (state_d == ST_IDLE)) begin
      bus_request <= 1'b0;
    end
  end

  // Acks are masked by rst so a reset edge swallows a coincident completion.
  assign if_ack   = !rst && bus_valid && (state_q == ST_GNT_IF);
  assign dm_ack   = !rst && bus_valid && (state_q == ST_GNT_DM);
  assign if_rdata = if_ack ? bus_rdata : 32'd0;
  assign dm_rdata = (dm_ack && !bus_we_re) ? bus_rdata : 32'd0;

endmodule
